// File: rtl/uart_pkg.sv
// Shared constants and types for the UART baud-rate generator.
// The optional fractional divider is selected with the UART_BAUD_FRAC_EN macro.
package uart_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_FRAC_W = 4;
    localparam int DEF_OVS    = 16;
    localparam int DEF_OVS_W  = 4;

    // Oversample phase at which the RX strobe lands in the middle of a bit.
    localparam int RX_MID = DEF_OVS / 2 - 1;

    typedef struct packed {
        logic [DEF_CNT_W-1:0]  ival;
        logic [DEF_FRAC_W-1:0] fval;
    } div_rec_t;

    function automatic int rx_mid_of(input int ovs);
        return ovs / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional clock divider with a shadowed, glitch-free divisor update.
// UART_BAUD_FRAC_EN adds the fractional accumulator; without it periods are exactly div_int.
module uart_frac_div import uart_pkg::*; #(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              div_we,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              step,
    output logic              div_pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_int;
    logic [CNT_W-1:0] shd_int;
    logic [CNT_W-1:0] nxt_int;
    logic             apply;
    logic             carry;

    // A write in the same cycle as an apply must win, so the apply path reads the incoming value.
    assign nxt_int = div_we ? div_int : shd_int;
    assign apply   = !en || (cnt == '0) || (act_int == '0);
    assign step    = en && (cnt == '0) && (act_int != '0);

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] shd_frac;
    logic [FRAC_W-1:0] nxt_frac;
    logic [FRAC_W:0]   frac_sum;

    assign nxt_frac = div_we ? div_frac : shd_frac;
    assign frac_sum = {1'b0, frac_acc} + {1'b0, nxt_frac};
    assign carry    = frac_sum[FRAC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            frac_acc <= '0;
            act_frac <= '0;
            shd_frac <= '0;
        end else begin
            if (div_we) shd_frac <= div_frac;
            if (apply)  act_frac <= nxt_frac;
            if (!en)        frac_acc <= '0;
            else if (step)  frac_acc <= frac_sum[FRAC_W-1:0];
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign carry       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            act_int  <= '0;
            shd_int  <= '0;
            div_pend <= 1'b0;
        end else begin
            if (div_we) shd_int <= div_int;
            if (apply) begin
                act_int  <= nxt_int;
                div_pend <= 1'b0;
            end else if (div_we) begin
                div_pend <= 1'b1;
            end
            // Reload uses the divisor applied at this terminal count; a zero divisor parks at 0.
            if (!en)
                cnt <= '0;
            else if (step)
                cnt <= (nxt_int == '0) ? '0 : nxt_int - CNT_W'(1) + CNT_W'(carry);
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: oversample tick plus free-running TX and resyncable RX phase strobes.
// Fractional division is present only when UART_BAUD_FRAC_EN is defined.
module uart_baud_gen import uart_pkg::*; #(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OVS    = DEF_OVS,
    parameter int OVS_W  = DEF_OVS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              div_we,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              rx_sync,
    output logic              tick_ovs,
    output logic              tick_rx,
    output logic              tick_tx,
    output logic              div_pend
);

    localparam logic [OVS_W-1:0] TX_LAST = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0] RX_MIDP = OVS_W'(rx_mid_of(OVS));

    logic             step;
    logic [OVS_W-1:0] tx_phase;
    logic [OVS_W-1:0] rx_phase;

    uart_frac_div #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_we   (div_we),
        .div_int  (div_int),
        .div_frac (div_frac),
        .step     (step),
        .div_pend (div_pend)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            tx_phase <= '0;
            rx_phase <= '0;
            tick_ovs <= 1'b0;
            tick_tx  <= 1'b0;
            tick_rx  <= 1'b0;
        end else begin
            tick_ovs <= step;
            tick_tx  <= step && (tx_phase == TX_LAST);
            if (step) tx_phase <= tx_phase + OVS_W'(1);
            // A start edge realigns RX and swallows any strobe that would fire on the same edge.
            if (rx_sync) begin
                rx_phase <= '0;
                tick_rx  <= 1'b0;
            end else begin
                tick_rx <= step && (rx_phase == RX_MIDP);
                if (step) rx_phase <= rx_phase + OVS_W'(1);
            end
        end
    end

endmodule
